// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side scheduling blocks:
// scheduler state encoding, counter width and transmitter word length.
package uart_pkg;

    localparam int SCHED_CNT_W = 10;
    localparam int XMIT_WORD_W = 8;

    typedef enum logic [2:0] {
        X_SCHED_IDLE      = 3'd0,
        X_SCHED_ISSUE     = 3'd1,
        X_SCHED_WAIT_BUSY = 3'd2,
        X_SCHED_WAIT_DONE = 3'd3,
        X_SCHED_GAP       = 3'd4
    } sched_state_e;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [SCHED_CNT_W-1:0] sat_inc(input logic [SCHED_CNT_W-1:0] v);
        return (&v) ? v : v + SCHED_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Round-robin arbiter: searches upward from the last winner, modulo N.
// The pointer only moves when the caller reports that the grant was taken.
module uart_rr_arb #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    int               cand;

    always_comb begin
        found       = 1'b0;
        grant_idx_o = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) cand = cand - N;
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found       = 1'b1;
                grant_idx_o = cand_idx;
            end
        end
        grant_o = found ? (N'(1) << grant_idx_o) : '0;
        any_o   = found;
    end

    // Reset to N-1 so requester 0 is searched first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= IDX_W'(N - 1);
        end else if (advance_i && found) begin
            ptr_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/uart_xmit_sched.sv
// Shares one UART transmitter among N_REQ byte requesters: round-robin accept,
// one-cycle start pulse, done-flag tracking with timeouts, then an inter-frame gap.
module uart_xmit_sched #(
    parameter int N_REQ        = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 4,
    parameter int DONE_TIMEOUT = 511,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               xmit_req,
    output logic [7:0]         xmit_data,
    input  logic               xmit_done,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               frame_done,
    output logic               err_timeout
);
    import uart_pkg::*;

    localparam logic [SCHED_CNT_W-1:0] BUSY_LAST = SCHED_CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [SCHED_CNT_W-1:0] DONE_LAST = SCHED_CNT_W'(DONE_TIMEOUT - 1);
    localparam logic [SCHED_CNT_W-1:0] GAP_LAST  = SCHED_CNT_W'(GAP_CYCLES);

    sched_state_e             state_q;
    logic [SCHED_CNT_W-1:0]   cnt_q;
    logic                     xmit_req_q;
    logic [XMIT_WORD_W-1:0]   xmit_data_q;
    logic [ID_W-1:0]          grant_id_q;
    logic                     busy_q;
    logic                     frame_done_q;
    logic                     err_timeout_q;

    logic [N_REQ-1:0]         arb_grant;
    logic [ID_W-1:0]          arb_idx;
    logic                     arb_any;
    logic                     accept;
    logic [XMIT_WORD_W-1:0]   sel_byte;

    // Grants are only offered while idle, with the transmitter idle and out of reset.
    assign accept    = !sys_rst && (state_q == X_SCHED_IDLE) && xmit_done && arb_any;
    assign req_ready = accept ? arb_grant : '0;

    uart_rr_arb #(.N(N_REQ)) u_arb (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .req_i       (req_valid),
        .advance_i   (accept),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == ID_W'(i)) sel_byte = req_data[i*8 +: 8];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= X_SCHED_IDLE;
            cnt_q         <= '0;
            xmit_req_q    <= 1'b0;
            xmit_data_q   <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            xmit_req_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                X_SCHED_IDLE: begin
                    if (accept) begin
                        xmit_data_q <= sel_byte;
                        grant_id_q  <= arb_idx;
                        xmit_req_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= X_SCHED_ISSUE;
                    end
                end
                X_SCHED_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= X_SCHED_WAIT_BUSY;
                end
                X_SCHED_WAIT_BUSY: begin
                    if (!xmit_done) begin
                        cnt_q   <= '0;
                        state_q <= X_SCHED_WAIT_DONE;
                    end else if (cnt_q == BUSY_LAST) begin
                        err_timeout_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= X_SCHED_GAP;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                X_SCHED_WAIT_DONE: begin
                    if (xmit_done) begin
                        frame_done_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= X_SCHED_GAP;
                    end else if (cnt_q == DONE_LAST) begin
                        err_timeout_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= X_SCHED_GAP;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                X_SCHED_GAP: begin
                    // GAP_CYCLES idle cycles after the cycle the frame ended in.
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= X_SCHED_IDLE;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= X_SCHED_IDLE;
                end
            endcase
        end
    end

    assign xmit_req    = xmit_req_q;
    assign xmit_data   = xmit_data_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_xmit_sched.sv
// Bench for uart_xmit_sched: transmitter model, event monitor and scenario tasks
// checked against a round-robin reference and frame-timing arithmetic.
module tb_uart_xmit_sched;

    localparam int N    = 4;
    localparam int GAP  = 2;
    localparam int BTO  = 4;
    localparam int DTO  = 511;

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           xmit_req;
    logic [7:0]     xmit_data;
    logic           xmit_done;
    logic [1:0]     grant_id;
    logic           busy;
    logic           frame_done;
    logic           err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int last_model;

    // Transmitter model: 0 = normal frame of tx_len cycles, 1 = never starts, 2 = manual flag.
    int   tx_mode = 0;
    int   tx_len  = 10;
    int   tx_cnt  = 0;
    logic model_done = 1'b1;
    logic man_done   = 1'b1;

    assign xmit_done = (tx_mode == 2) ? man_done : model_done;

    always #5 sys_clk = ~sys_clk;

    uart_xmit_sched #(
        .N_REQ(N), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BTO), .DONE_TIMEOUT(DTO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .xmit_req    (xmit_req),
        .xmit_data   (xmit_data),
        .xmit_done   (xmit_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout)
    );

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            tx_cnt     <= 0;
            model_done <= 1'b1;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) model_done <= 1'b1;
        end else if (xmit_req && tx_mode == 0) begin
            model_done <= 1'b0;
            tx_cnt     <= tx_len;
        end
    end

    // Event monitor: records accepts, start pulses and completions with cycle stamps.
    int         cyc = 0;
    int         viol = 0;
    int         mon_k;
    logic       prev_busy = 1'b0;
    logic       prev_xreq = 1'b0;
    int         acc_idx_q[$];
    int         acc_cyc_q[$];
    logic [N-1:0] acc_rdy_q[$];
    int         xr_cyc_q[$];
    int         xr_id_q[$];
    logic [7:0] xr_dat_q[$];
    int         fd_cyc_q[$];
    int         to_cyc_q[$];
    int         idle_cyc_q[$];
    logic [7:0] exp_q[$];
    int         exp_idx_q[$];

    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (sys_rst) begin
            prev_busy = 1'b0;
            prev_xreq = 1'b0;
        end else begin
            if (req_ready != '0) begin
                mon_k = 0;
                for (int k = N - 1; k >= 0; k--) if (req_ready[k]) mon_k = k;
                acc_idx_q.push_back(mon_k);
                acc_cyc_q.push_back(cyc);
                acc_rdy_q.push_back(req_ready);
            end
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0 || (busy && req_ready != '0))
                viol = viol + 1;
            if (xmit_req) begin
                if (prev_xreq) viol = viol + 1;
                xr_cyc_q.push_back(cyc);
                xr_id_q.push_back(int'(grant_id));
                xr_dat_q.push_back(xmit_data);
            end
            if (frame_done) fd_cyc_q.push_back(cyc);
            if (err_timeout) to_cyc_q.push_back(cyc);
            if (frame_done && err_timeout) viol = viol + 1;
            if (prev_busy && !busy) idle_cyc_q.push_back(cyc);
            prev_busy = busy;
            prev_xreq = xmit_req;
        end
    end

    // Reference rule: first valid index after the last winner, modulo N.
    function automatic int rr_next(input int last, input logic [N-1:0] mask);
        for (int s = 1; s <= N; s++) begin
            if (mask[(last + s) % N]) return (last + s) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_q();
        acc_idx_q.delete(); acc_cyc_q.delete(); acc_rdy_q.delete();
        xr_cyc_q.delete(); xr_id_q.delete(); xr_dat_q.delete();
        fd_cyc_q.delete(); to_cyc_q.delete(); idle_cyc_q.delete();
        exp_q.delete(); exp_idx_q.delete();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; req_valid = '1; req_data = '0; tx_mode = 0; man_done = 1'b1;
        repeat (3) tick();
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_checks++; if (xmit_req !== 1'b0) begin n_fail++; $display("FAIL reset_xmit_req: got %b want 0", xmit_req); end
        n_checks++; if (xmit_data !== 8'h00) begin n_fail++; $display("FAIL reset_xmit_data: got %h want 00", xmit_data); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
        req_valid = '0;
        sys_rst = 1'b0;
        repeat (2) tick();
        n_checks++; if (busy !== 1'b0 || xmit_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: busy %b xmit_req %b want 0 0", busy, xmit_req); end
        last_model = N - 1;
    endtask

    task automatic test_single();
        int exp;
        clear_q();
        tx_mode = 0; tx_len = 170;
        req_data[7:0] = 8'hA5; req_valid = 4'b0001;
        for (int t = 0; t < 20 && acc_idx_q.size() < 1; t++) tick();
        req_valid = '0;
        n_checks++; if (acc_idx_q.size() != 1) begin n_fail++; $display("FAIL single_accept: got %0d accepts want 1", acc_idx_q.size()); return; end
        exp = rr_next(last_model, 4'b0001);
        n_checks++; if (acc_idx_q[0] != exp) begin n_fail++; $display("FAIL single_idx: got %0d want %0d", acc_idx_q[0], exp); end
        n_checks++; if (acc_rdy_q[0] !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", acc_rdy_q[0]); end
        for (int t = 0; t < 5 && xr_cyc_q.size() < 1; t++) tick();
        n_checks++; if (xr_cyc_q.size() != 1) begin n_fail++; $display("FAIL single_xreq: got %0d pulses want 1", xr_cyc_q.size()); return; end
        n_checks++; if (xr_cyc_q[0] - acc_cyc_q[0] != 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", xr_cyc_q[0] - acc_cyc_q[0]); end
        n_checks++; if (xr_dat_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", xr_dat_q[0]); end
        n_checks++; if (xr_id_q[0] != 0) begin n_fail++; $display("FAIL single_grant_id: got %0d want 0", xr_id_q[0]); end
        for (int t = 0; t < 400 && fd_cyc_q.size() < 1; t++) tick();
        n_checks++; if (fd_cyc_q.size() != 1) begin n_fail++; $display("FAIL single_frame_done: got %0d want 1", fd_cyc_q.size()); return; end
        n_checks++; if (fd_cyc_q[0] - xr_cyc_q[0] != tx_len + 1) begin n_fail++; $display("FAIL single_fd_time: got %0d want %0d", fd_cyc_q[0] - xr_cyc_q[0], tx_len + 1); end
        n_checks++; if (to_cyc_q.size() != 0) begin n_fail++; $display("FAIL single_no_timeout: got %0d want 0", to_cyc_q.size()); end
        for (int t = 0; t < 20 && idle_cyc_q.size() < 1; t++) tick();
        n_checks++; if (idle_cyc_q.size() != 1) begin n_fail++; $display("FAIL single_idle: got %0d want 1", idle_cyc_q.size()); return; end
        n_checks++; if (idle_cyc_q[0] - fd_cyc_q[0] != GAP + 1) begin n_fail++; $display("FAIL single_gap: got %0d want %0d", idle_cyc_q[0] - fd_cyc_q[0], GAP + 1); end
        last_model = exp;
    endtask

    task automatic test_round_robin();
        int m;
        clear_q();
        tx_len = $urandom_range(2, 30);
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        m = last_model;
        for (int i = 0; i < 5; i++) begin
            m = rr_next(m, 4'b1111);
            exp_idx_q.push_back(m);
            exp_q.push_back(8'h10 + 8'(m));
        end
        req_valid = 4'b1111;
        for (int t = 0; t < 500 && acc_idx_q.size() < 5; t++) tick();
        req_valid = '0;
        for (int t = 0; t < 100 && idle_cyc_q.size() < 5; t++) tick();
        n_checks++; if (acc_idx_q.size() != 5 || xr_dat_q.size() != 5) begin n_fail++; $display("FAIL rr_count: got %0d/%0d want 5/5", acc_idx_q.size(), xr_dat_q.size()); return; end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (acc_idx_q[i] != exp_idx_q[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, acc_idx_q[i], exp_idx_q[i]); end
            n_checks++; if (xr_dat_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, xr_dat_q[i], exp_q[i]); end
        end
        last_model = m;
    endtask

    task automatic test_random();
        int m;
        logic [N-1:0] mask;
        logic [7:0]   dat [N];
        clear_q();
        m = last_model;
        for (int it = 0; it < 12; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++) begin
                dat[r] = 8'($urandom);
                req_data[r*8 +: 8] = dat[r];
            end
            m = rr_next(m, mask);
            exp_idx_q.push_back(m);
            exp_q.push_back(dat[m]);
            tx_len = $urandom_range(2, 40);
            req_valid = mask;
            for (int t = 0; t < 200 && acc_idx_q.size() < it + 1; t++) tick();
            if (acc_idx_q.size() < it + 1) break;
        end
        req_valid = '0;
        for (int t = 0; t < 200 && idle_cyc_q.size() < 12; t++) tick();
        n_checks++; if (acc_idx_q.size() != 12 || xr_dat_q.size() != 12 || fd_cyc_q.size() != 12) begin
            n_fail++; $display("FAIL rand_count: acc %0d xreq %0d done %0d want 12 each", acc_idx_q.size(), xr_dat_q.size(), fd_cyc_q.size()); return;
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (acc_idx_q[i] != exp_idx_q[i]) begin n_fail++; $display("FAIL rand_idx[%0d]: got %0d want %0d", i, acc_idx_q[i], exp_idx_q[i]); end
            n_checks++; if (xr_dat_q[i] !== exp_q[i] || xr_id_q[i] != exp_idx_q[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h/%0d want %h/%0d", i, xr_dat_q[i], xr_id_q[i], exp_q[i], exp_idx_q[i]); end
            n_checks++; if (xr_cyc_q[i] - acc_cyc_q[i] != 1) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want 1", i, xr_cyc_q[i] - acc_cyc_q[i]); end
        end
        n_checks++; if (to_cyc_q.size() != 0) begin n_fail++; $display("FAIL rand_no_timeout: got %0d want 0", to_cyc_q.size()); end
        last_model = m;
    endtask

    task automatic test_skip();
        clear_q();
        tx_len = 5;
        req_valid = 4'b0100;
        for (int t = 0; t < 100 && acc_idx_q.size() < 1; t++) tick();
        req_valid = 4'b1010;
        for (int t = 0; t < 200 && acc_idx_q.size() < 3; t++) tick();
        req_valid = '0;
        for (int t = 0; t < 100 && idle_cyc_q.size() < 3; t++) tick();
        n_checks++; if (acc_idx_q.size() != 3) begin n_fail++; $display("FAIL skip_count: got %0d want 3", acc_idx_q.size()); return; end
        n_checks++; if (acc_idx_q[0] != 2) begin n_fail++; $display("FAIL skip_first: got %0d want 2", acc_idx_q[0]); end
        n_checks++; if (acc_idx_q[1] != 3) begin n_fail++; $display("FAIL skip_second: got %0d want 3", acc_idx_q[1]); end
        n_checks++; if (acc_idx_q[2] != 1) begin n_fail++; $display("FAIL skip_third: got %0d want 1", acc_idx_q[2]); end
        last_model = 1;
    endtask

    task automatic test_busy_timeout();
        clear_q();
        tx_mode = 1;
        req_data[7:0] = 8'h3C; req_valid = 4'b0001;
        for (int t = 0; t < 60 && acc_idx_q.size() < 2; t++) tick();
        req_valid = '0;
        for (int t = 0; t < 40 && (to_cyc_q.size() < 2 || idle_cyc_q.size() < 2); t++) tick();
        tx_mode = 0;
        n_checks++; if (acc_idx_q.size() != 2 || to_cyc_q.size() != 2 || xr_cyc_q.size() != 2) begin
            n_fail++; $display("FAIL bto_count: acc %0d timeouts %0d xreq %0d want 2 each", acc_idx_q.size(), to_cyc_q.size(), xr_cyc_q.size()); return;
        end
        n_checks++; if (to_cyc_q[0] - xr_cyc_q[0] != BTO + 1) begin n_fail++; $display("FAIL bto_time: got %0d want %0d", to_cyc_q[0] - xr_cyc_q[0], BTO + 1); end
        n_checks++; if (fd_cyc_q.size() != 0) begin n_fail++; $display("FAIL bto_no_frame_done: got %0d want 0", fd_cyc_q.size()); end
        n_checks++; if (acc_cyc_q[1] - to_cyc_q[0] != GAP + 1) begin n_fail++; $display("FAIL bto_regrant: got %0d want %0d", acc_cyc_q[1] - to_cyc_q[0], GAP + 1); end
        n_checks++; if (acc_idx_q[1] != 0) begin n_fail++; $display("FAIL bto_regrant_idx: got %0d want 0", acc_idx_q[1]); end
        last_model = 0;
    endtask

    task automatic test_done_timeout();
        int exp;
        clear_q();
        tx_mode = 2; man_done = 1'b1;
        req_data[15:8] = 8'h5A; req_valid = 4'b0010;
        exp = rr_next(last_model, 4'b0010);
        for (int t = 0; t < 20 && xr_cyc_q.size() < 1; t++) tick();
        man_done = 1'b0;
        n_checks++; if (acc_idx_q.size() != 1 || xr_cyc_q.size() != 1) begin n_fail++; $display("FAIL dto_start: acc %0d xreq %0d want 1 1", acc_idx_q.size(), xr_cyc_q.size()); man_done = 1'b1; tx_mode = 0; return; end
        n_checks++; if (acc_idx_q[0] != exp) begin n_fail++; $display("FAIL dto_idx: got %0d want %0d", acc_idx_q[0], exp); end
        repeat (600) tick();
        n_checks++; if (to_cyc_q.size() != 1) begin n_fail++; $display("FAIL dto_timeout: got %0d want 1", to_cyc_q.size()); end
        else begin
            n_checks++; if (to_cyc_q[0] - xr_cyc_q[0] != DTO + 2) begin n_fail++; $display("FAIL dto_time: got %0d want %0d", to_cyc_q[0] - xr_cyc_q[0], DTO + 2); end
        end
        n_checks++; if (fd_cyc_q.size() != 0) begin n_fail++; $display("FAIL dto_no_frame_done: got %0d want 0", fd_cyc_q.size()); end
        n_checks++; if (acc_idx_q.size() != 1 || idle_cyc_q.size() != 1) begin n_fail++; $display("FAIL dto_hold: acc %0d idle %0d want 1 1", acc_idx_q.size(), idle_cyc_q.size()); end
        man_done = 1'b1;
        for (int t = 0; t < 10 && acc_idx_q.size() < 2; t++) tick();
        req_valid = '0;
        n_checks++; if (acc_idx_q.size() != 2) begin n_fail++; $display("FAIL dto_regrant: got %0d accepts want 2", acc_idx_q.size()); end
        else begin
            n_checks++; if (acc_idx_q[1] != 1) begin n_fail++; $display("FAIL dto_regrant_idx: got %0d want 1", acc_idx_q[1]); end
        end
        for (int t = 0; t < 40 && idle_cyc_q.size() < 2; t++) tick();
        tx_mode = 0;
        last_model = 1;
    endtask

    task automatic test_reset_mid();
        clear_q();
        tx_mode = 0; tx_len = 200;
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req_valid = 4'b0001;
        for (int t = 0; t < 20 && acc_idx_q.size() < 1; t++) tick();
        req_valid = 4'b1111;
        repeat (20) tick();
        #3;
        sys_rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || xmit_req !== 1'b0 || req_ready !== '0) begin n_fail++; $display("FAIL rst_mid_ctrl: busy %b xmit_req %b ready %b want 0 0 0", busy, xmit_req, req_ready); end
        n_checks++; if (xmit_data !== 8'h00 || grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_mid_data: data %h id %0d want 00 0", xmit_data, grant_id); end
        n_checks++; if (frame_done !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulses: fd %b to %b want 0 0", frame_done, err_timeout); end
        tx_len = 5;
        repeat (2) tick();
        sys_rst = 1'b0;
        for (int t = 0; t < 20 && acc_idx_q.size() < 2; t++) tick();
        req_valid = '0;
        n_checks++; if (acc_idx_q.size() != 2) begin n_fail++; $display("FAIL rst_mid_regrant: got %0d accepts want 2", acc_idx_q.size()); return; end
        n_checks++; if (acc_idx_q[0] != 0 || acc_idx_q[1] != 0) begin n_fail++; $display("FAIL rst_mid_priority: got %0d,%0d want 0,0", acc_idx_q[0], acc_idx_q[1]); end
        n_checks++; if (fd_cyc_q.size() != 0 || to_cyc_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_no_pulse: fd %0d to %0d want 0 0", fd_cyc_q.size(), to_cyc_q.size()); end
        for (int t = 0; t < 50 && idle_cyc_q.size() < 1; t++) tick();
        last_model = 0;
    endtask

    task automatic test_protocol();
        n_checks++; if (viol != 0) begin n_fail++; $display("FAIL protocol: got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_random();
        test_skip();
        test_busy_timeout();
        test_done_timeout();
        test_reset_mid();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
